// File: rtl/gbe_ctr_scheduler_pkg.sv
// gbe_ctr_pkg: shared state type, control-word bit positions and field widths
package gbe_ctr_pkg;
  typedef enum logic [1:0] {SNAP, SHOW, MANUAL} state_t;
  localparam int CLR_BIT = 0;
  localparam int FRZ_BIT = 1;
  localparam int MAN_BIT = 2;
  localparam int MIDX_LSB = 8;
  localparam int IDX_W = 8;
  localparam int VAL_W = 24;
endpackage

// File: rtl/gbe_ctr_scheduler_if.sv
// gbe_ctr_scheduler_if: event/control inputs and status-register outputs of the counter scheduler
interface gbe_ctr_scheduler_if
  import gbe_ctr_pkg::*;
#(
  parameter int N_CTR = 4
);
  logic [N_CTR-1:0] event_in;
  logic [31:0] ctrl_in;
  logic [31:0] user_data_out;
  logic [IDX_W-1:0] seq_idx;
  logic snap_done;
  modport master (output event_in, ctrl_in, input user_data_out, seq_idx, snap_done);
  modport slave (input event_in, ctrl_in, output user_data_out, seq_idx, snap_done);
endinterface

// File: rtl/gbe_ctr_scheduler_sat_counter.sv
// gbe_sat_counter: saturating event counter; clear wins over increment
module gbe_sat_counter #(
  parameter int W = 24
) (
  input  logic         user_clk,
  input  logic         user_rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/gbe_ctr_scheduler.sv
// gbe_ctr_scheduler: counter bank snapshotted and rotated onto one 32-bit status word
module gbe_ctr_scheduler
  import gbe_ctr_pkg::*;
#(
  parameter int N_CTR = 4,
  parameter int CTR_W = 24,
  parameter int DWELL = 1024
) (
  input logic user_clk,
  input logic user_rst_n,
  gbe_ctr_scheduler_if.slave bus
);
  localparam int DW_W = $clog2(DWELL);
  localparam int SEL_W = N_CTR > 1 ? $clog2(N_CTR) : 1;
  localparam logic [DW_W-1:0] RELOAD = DW_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CTR - 1);
  localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_CTR);
  logic [CTR_W-1:0] cnt [N_CTR];
  logic [CTR_W-1:0] shadow [N_CTR];
  state_t state;
  logic [IDX_W-1:0] idx, midx;
  logic [DW_W-1:0] dwell;
  logic clr_q, clr, frz, man;
  logic [CTR_W-1:0] man_val, show_val;
  logic unused;
  assign clr = bus.ctrl_in[CLR_BIT] & ~clr_q;
  assign frz = bus.ctrl_in[FRZ_BIT];
  assign man = bus.ctrl_in[MAN_BIT];
  assign midx = bus.ctrl_in[MIDX_LSB +: IDX_W];
  assign man_val = {1'b0, midx} < N_LIM ? cnt[midx[SEL_W-1:0]] : '0;
  assign show_val = shadow[idx[SEL_W-1:0]];
  assign unused = ^{bus.ctrl_in[31:MIDX_LSB+IDX_W], bus.ctrl_in[MIDX_LSB-1:MAN_BIT+1]};
  for (genvar i = 0; i < N_CTR; i++) begin : g_ctr
    gbe_sat_counter #(.W(CTR_W)) u_ctr (
      .user_clk  (user_clk),
      .user_rst_n(user_rst_n),
      .clr       (clr),
      .inc       (bus.event_in[i]),
      .cnt       (cnt[i])
    );
  end
  // Manual mode overrides everything; freeze only stalls the automatic rotation.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state <= SNAP;
      idx <= '0;
      dwell <= '0;
      clr_q <= 1'b0;
      bus.user_data_out <= '0;
      bus.seq_idx <= '0;
      bus.snap_done <= 1'b0;
      for (int i = 0; i < N_CTR; i++) shadow[i] <= '0;
    end else begin
      clr_q <= bus.ctrl_in[CLR_BIT];
      bus.snap_done <= 1'b0;
      if (man) begin
        state <= MANUAL;
        idx <= '0;
        bus.user_data_out <= {midx, VAL_W'(man_val)};
        bus.seq_idx <= midx;
      end else if (state == MANUAL) begin
        state <= SNAP;
        idx <= '0;
      end else if (!frz && state == SNAP) begin
        for (int i = 0; i < N_CTR; i++) shadow[i] <= cnt[i];
        dwell <= RELOAD;
        state <= SHOW;
      end else if (!frz) begin
        bus.user_data_out <= {idx, VAL_W'(show_val)};
        bus.seq_idx <= idx;
        dwell <= dwell - DW_W'(1);
        if (dwell == '0) begin
          dwell <= RELOAD;
          idx <= idx == LAST ? '0 : idx + IDX_W'(1);
          state <= idx == LAST ? SNAP : SHOW;
          bus.snap_done <= idx == LAST;
        end
      end
    end
  end
endmodule

// File: tb/tb_gbe_ctr_scheduler.sv
// tb_gbe_ctr_scheduler: scoreboard bench for rotation, clear, saturation, freeze, manual and reset
module tb_gbe_ctr_scheduler;
  import gbe_ctr_pkg::*;
  typedef struct {logic [31:0] w; int len;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, failures = 0, cyc = 0, t_last = 0, prev_len = 0;
  logic [31:0] last = '0;
  bit sat_done = 1'b0;
  exp_t q[$];
  always #5 clk = ~clk;
  gbe_ctr_scheduler_if #(.N_CTR(4)) bus ();
  gbe_ctr_scheduler_if #(.N_CTR(4)) bus_s ();
  gbe_ctr_scheduler #(.N_CTR(4), .CTR_W(24), .DWELL(4)) dut (
    .user_clk(clk), .user_rst_n(rst_n), .bus(bus));
  gbe_ctr_scheduler #(.N_CTR(4), .CTR_W(4), .DWELL(4)) dut_s (
    .user_clk(clk), .user_rst_n(rst_n), .bus(bus_s));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(logic [31:0] w, int len);
    exp_t e;
    e.w = w;
    e.len = len;
    q.push_back(e);
  endtask

  task automatic rot(logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3, int l3);
    push(w0, 4);
    push(w1, 4);
    push(w2, 4);
    push(w3, l3);
  endtask

  task automatic wait_snap(output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.snap_done && n < 64);
    chk("snap_seen", 32'(bus.snap_done), 32'd1);
    t = int'($time);
  endtask

  // Every change of the status word pops the next expected word and checks how long the previous one was held.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      last = bus.user_data_out;
      prev_len = 0;
      t_last = cyc;
    end else if (bus.user_data_out !== last) begin
      if (prev_len != 0) chk("hold_len", cyc - t_last, prev_len);
      prev_len = 0;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("word", bus.user_data_out, e.w);
        prev_len = e.len;
      end
      last = bus.user_data_out;
      t_last = cyc;
    end
  end

  initial begin
    int n;
    bus_s.event_in = '0;
    bus_s.ctrl_in = '0;
    @(posedge rst_n);
    bus_s.event_in = 4'b1000;
    repeat (20) @(negedge clk);
    bus_s.event_in = '0;
    repeat (40) @(negedge clk);
    n = 0;
    while (bus_s.user_data_out[31:24] != 8'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sat_word", bus_s.user_data_out, 32'h0300000F);
    chk("sat_cnt", 32'(dut_s.cnt[3]), 32'd15);
    sat_done = 1'b1;
  end

  initial begin
    int t1, t2, n;
    bus.event_in = '0;
    bus.ctrl_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.user_data_out, 32'h0);
    chk("rst_idx", 32'(bus.seq_idx), 32'h0);
    chk("rst_snap", 32'(bus.snap_done), 32'h0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.event_in = {1'b0, i < 3, 1'b0, 1'b1};
      @(negedge clk);
    end
    bus.event_in = '0;
    wait_snap(t1);
    rot(32'h00000005, 32'h01000000, 32'h02000003, 32'h03000000, 5);
    @(negedge clk);
    chk("snap_width", 32'(bus.snap_done), 32'd0);
    wait_snap(t2);
    chk("snap_period", t2 - t1, 170);
    bus.event_in = 4'b0010;
    repeat (7) @(negedge clk);
    bus.event_in = '0;
    wait_snap(t1);
    rot(32'h00000005, 32'h01000007, 32'h02000003, 32'h03000000, 5);
    bus.ctrl_in = 32'h1;
    bus.event_in = 4'b0010;
    @(negedge clk);
    bus.event_in = '0;
    chk("clr_beats_inc", 32'(dut.cnt[1]), 32'd0);
    wait_snap(t1);
    bus.ctrl_in = 32'h0;
    push(32'h00000000, 4);
    push(32'h01000000, 14);
    push(32'h02000000, 4);
    push(32'h03000000, 5);
    repeat (7) @(negedge clk);
    bus.ctrl_in = 32'h2;
    bus.event_in = 4'b0010;
    repeat (10) @(negedge clk);
    bus.ctrl_in = 32'h0;
    bus.event_in = '0;
    wait_snap(t1);
    rot(32'h00000000, 32'h0100000A, 32'h02000000, 32'h03000000, 4);
    bus.event_in = 4'b0100;
    repeat (3) @(negedge clk);
    bus.event_in = '0;
    wait_snap(t1);
    bus.ctrl_in = 32'h0204;
    push(32'h02000003, 2);
    push(32'h02000004, 2);
    push(32'h09000000, 5);
    rot(32'h00000000, 32'h0100000A, 32'h02000004, 32'h03000000, 5);
    @(negedge clk);
    bus.event_in = 4'b0100;
    @(negedge clk);
    bus.event_in = '0;
    chk("man_idx", 32'(bus.seq_idx), 32'd2);
    repeat (2) @(negedge clk);
    bus.ctrl_in = 32'h0904;
    @(negedge clk);
    chk("man_oor", bus.user_data_out, 32'h09000000);
    chk("man_oor_idx", 32'(bus.seq_idx), 32'd9);
    repeat (2) @(negedge clk);
    bus.ctrl_in = 32'h0;
    wait_snap(t1);
    repeat (6) @(negedge clk);
    chk("pre_rst_word", bus.user_data_out, 32'h0100000A);
    #2 rst_n = 1'b0;
    #1;
    chk("async_data", bus.user_data_out, 32'h0);
    chk("async_idx", 32'(bus.seq_idx), 32'h0);
    chk("async_snap", 32'(bus.snap_done), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    push(32'h01000000, 4);
    push(32'h02000000, 4);
    push(32'h03000000, 5);
    repeat (5) @(negedge clk);
    chk("post_rst_w0", bus.user_data_out, 32'h0);
    chk("post_rst_i0", 32'(bus.seq_idx), 32'd0);
    @(negedge clk);
    chk("post_rst_w1", bus.user_data_out, 32'h01000000);
    chk("post_rst_i1", 32'(bus.seq_idx), 32'd1);
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", q.size(), 0);
    repeat (8) @(negedge clk);
    n = 0;
    while (!sat_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sat_finished", 32'(sat_done), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
